regfile_multiport: RTL and testbench

Parametrised multi-port general-purpose register file for the dual-issue core, succeeding the single-write, two-read register file. It provides NUM_WR write lanes, NUM_RD read ports with same-cycle write-to-read bypass, and a per-register pending scoreboard for issue-stage hazard checks. A post-reset clear sequencer zeroes every entry, so no reset fan-out to the array is needed. It sits between decode/issue (reads, pending marks) and writeback (write lanes).

---
 rtl/regfile_multiport.sv | 113 +++++++++++
 tb/tb_regfile_multiport.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_multiport.sv
// Multi-lane register file: NUM_WR write lanes, NUM_RD bypassed read ports,
// per-entry pending scoreboard and a post-reset clear sequencer.
module regfile_multiport #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 4,
  parameter int NUM_WR = 2
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic [NUM_WR-1:0]        wr_en_i,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
  input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o,
  output logic [NUM_RD-1:0]        rd_pend_o,
  input  logic                     pend_set_i,
  input  logic [ADDR_W-1:0]        pend_set_addr_i,
  output logic                     init_busy_o
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST = '1;

  typedef enum logic {INIT, RUN} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DEPTH-1:0]  pend_q, pend_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              busy;

  assign busy        = (state_q == INIT);
  assign init_busy_o = busy;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= INIT;
      cnt_q   <= ONE;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      INIT: begin
        if (cnt_q == LAST) state_d = RUN;
        else cnt_d = cnt_q + ONE;
      end
      RUN: ;
      default: state_d = INIT;
    endcase
  end

  // Set is applied after the clears so a newly issued producer wins.
  always_comb begin
    pend_d = pend_q;
    if (state_q == RUN) begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (wr_en_i[k])
          pend_d[wr_addr_i[k*ADDR_W +: ADDR_W]] = 1'b0;
      end
      if (pend_set_i)
        pend_d[pend_set_addr_i] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      if (state_q == INIT) begin
        mem_q[cnt_q] <= '0;
      end else begin
        for (int k = 0; k < NUM_WR; k++) begin
          if (wr_en_i[k] && wr_addr_i[k*ADDR_W +: ADDR_W] != '0)
            mem_q[wr_addr_i[k*ADDR_W +: ADDR_W]] <=
              wr_data_i[k*DATA_W +: DATA_W];
        end
      end
    end
  end

  for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic              hit;

    assign a = rd_addr_i[j*ADDR_W +: ADDR_W];

    always_comb begin
      d   = mem_q[a];
      hit = 1'b0;
      for (int k = 0; k < NUM_WR; k++) begin
        if (wr_en_i[k] && wr_addr_i[k*ADDR_W +: ADDR_W] == a) begin
          d   = wr_data_i[k*DATA_W +: DATA_W];
          hit = 1'b1;
        end
      end
    end

    assign rd_data_o[j*DATA_W +: DATA_W] =
      (busy || a == '0) ? '0 : d;
    assign rd_pend_o[j] = !busy && pend_q[a] && !hit;
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Self-checking bench for regfile_multiport: directed scenarios plus
// randomized traffic against an array/scoreboard reference model.
module tb_regfile_multiport;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 4;
  localparam int NW = 2;
  localparam int DEPTH = 1 << AW;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NW-1:0]        wr_en;
  logic [NW*AW-1:0]     wr_addr;
  logic [NW*DW-1:0]     wr_data;
  logic [NR*AW-1:0]     rd_addr;
  logic [NR*DW-1:0]     rd_data;
  logic [NR-1:0]        rd_pend;
  logic                 pset;
  logic [AW-1:0]        pset_addr;
  logic                 busy;

  int vectors = 0;
  int errors  = 0;

  logic [DW-1:0] model_mem [DEPTH];
  logic          model_pend [DEPTH];

  always #5 clk = ~clk;

  regfile_multiport #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)
  ) dut (
    .clock_i(clk),
    .reset_i(rst),
    .wr_en_i(wr_en),
    .wr_addr_i(wr_addr),
    .wr_data_i(wr_data),
    .rd_addr_i(rd_addr),
    .rd_data_o(rd_data),
    .rd_pend_o(rd_pend),
    .pend_set_i(pset),
    .pend_set_addr_i(pset_addr),
    .init_busy_o(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = '0;
    wr_addr = '0;
    wr_data = '0;
    pset = 1'b0;
    pset_addr = '0;
  endtask

  task automatic set_rd(input int j, input int a);
    rd_addr[j*AW +: AW] = AW'(a);
  endtask

  task automatic set_wr(input int k, input int a, input logic [DW-1:0] d);
    wr_en[k] = 1'b1;
    wr_addr[k*AW +: AW] = AW'(a);
    wr_data[k*DW +: DW] = d;
  endtask

  task automatic wait_init();
    int n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    vectors++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL init_timeout busy=%b want 0", busy);
    end
  endtask

  task automatic reset_and_init();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_init();
  endtask

  task automatic test_reset();
    int n;
    idle();
    for (int j = 0; j < NR; j++) set_rd(j, j + 1);
    rst = 1'b1;
    tick();
    #1;
    vectors++;
    if (busy !== 1'b1 || rd_data !== '0 || rd_pend !== '0) begin
      errors++;
      $display("FAIL reset_outputs busy=%b data=%h pend=%b want 1/0/0",
               busy, rd_data, rd_pend);
    end
    rst = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    vectors++;
    if (n != DEPTH - 1) begin
      errors++;
      $display("FAIL busy_cycles got=%0d want=%0d", n, DEPTH - 1);
    end
    for (int g = 0; g < DEPTH / NR; g++) begin
      for (int j = 0; j < NR; j++) set_rd(j, g * NR + j);
      #1;
      for (int j = 0; j < NR; j++) begin
        vectors++;
        if (rd_data[j*DW +: DW] !== '0 || rd_pend[j] !== 1'b0) begin
          errors++;
          $display("FAIL clear_read r%0d data=%h pend=%b want 0/0",
                   g * NR + j, rd_data[j*DW +: DW], rd_pend[j]);
        end
      end
      tick();
    end
  endtask

  task automatic test_init_write();
    int n;
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_wr(0, 5, 32'hDEADBEEF);
    pset = 1'b1;
    pset_addr = 5;
    set_rd(0, 5);
    #1;
    vectors++;
    if (rd_data[0 +: DW] !== '0 || rd_pend[0] !== 1'b0) begin
      errors++;
      $display("FAIL init_read_zero data=%h pend=%b want 0/0",
               rd_data[0 +: DW], rd_pend[0]);
    end
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    idle();
    #1;
    vectors++;
    if (busy !== 1'b0 || rd_data[0 +: DW] !== '0 || rd_pend[0] !== 1'b0) begin
      errors++;
      $display("FAIL init_write_ignored busy=%b r5=%h pend=%b want 0/0/0",
               busy, rd_data[0 +: DW], rd_pend[0]);
    end
  endtask

  task automatic test_bypass();
    idle();
    set_rd(2, 3);
    set_wr(0, 3, 32'h11111111);
    #1;
    vectors++;
    if (rd_data[2*DW +: DW] !== 32'h11111111) begin
      errors++;
      $display("FAIL bypass_r3 got=%h want=11111111", rd_data[2*DW +: DW]);
    end
    tick();
    idle();
    #1;
    vectors++;
    if (rd_data[2*DW +: DW] !== 32'h11111111) begin
      errors++;
      $display("FAIL array_r3 got=%h want=11111111", rd_data[2*DW +: DW]);
    end
    tick();
  endtask

  task automatic test_priority();
    idle();
    set_rd(0, 7);
    set_rd(3, 7);
    set_wr(0, 7, 32'hAAAA0000);
    set_wr(1, 7, 32'h0000BBBB);
    #1;
    vectors++;
    if (rd_data[0 +: DW] !== 32'h0000BBBB ||
        rd_data[3*DW +: DW] !== 32'h0000BBBB) begin
      errors++;
      $display("FAIL prio_bypass p0=%h p3=%h want 0000BBBB",
               rd_data[0 +: DW], rd_data[3*DW +: DW]);
    end
    tick();
    idle();
    #1;
    vectors++;
    if (rd_data[0 +: DW] !== 32'h0000BBBB) begin
      errors++;
      $display("FAIL prio_array got=%h want 0000BBBB", rd_data[0 +: DW]);
    end
    tick();
  endtask

  task automatic test_r0();
    idle();
    for (int j = 0; j < NR; j++) set_rd(j, 0);
    set_wr(0, 0, 32'hFFFFFFFF);
    set_wr(1, 0, 32'hFFFFFFFF);
    pset = 1'b1;
    pset_addr = 0;
    #1;
    vectors++;
    if (rd_data !== '0 || rd_pend !== '0) begin
      errors++;
      $display("FAIL r0_same data=%h pend=%b want 0/0", rd_data, rd_pend);
    end
    tick();
    idle();
    #1;
    vectors++;
    if (rd_data !== '0 || rd_pend !== '0) begin
      errors++;
      $display("FAIL r0_next data=%h pend=%b want 0/0", rd_data, rd_pend);
    end
    tick();
  endtask

  task automatic test_scoreboard();
    logic [7:0] want [8];
    logic [7:0] wv;
    wv = 8'b01000110;
    for (int i = 0; i < 8; i++) want[i] = {7'b0, wv[i]};
    idle();
    set_rd(1, 9);
    for (int t = 0; t < 7; t++) begin
      idle();
      if (t == 0 || t == 5) begin
        pset = 1'b1;
        pset_addr = 9;
      end
      if (t == 3) set_wr(1, 9, 32'h99990003);
      if (t == 5) set_wr(0, 9, 32'h99990005);
      #1;
      vectors++;
      if (rd_pend[1] !== want[t][0]) begin
        errors++;
        $display("FAIL pend_t%0d got=%b want=%b", t, rd_pend[1], want[t][0]);
      end
      tick();
    end
    idle();
    rst = 1'b1;
    tick();
    #1;
    vectors++;
    if (busy !== 1'b1 || rd_pend !== '0) begin
      errors++;
      $display("FAIL pend_reset busy=%b pend=%b want 1/0", busy, rd_pend);
    end
    rst = 1'b0;
    wait_init();
    #1;
    vectors++;
    if (rd_pend[1] !== 1'b0 || rd_data[DW +: DW] !== '0) begin
      errors++;
      $display("FAIL pend_after_reinit pend=%b data=%h want 0/0",
               rd_pend[1], rd_data[DW +: DW]);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] exp_d;
    logic          exp_p;
    int            a, wa;
    reset_and_init();
    for (int i = 0; i < DEPTH; i++) begin
      model_mem[i] = '0;
      model_pend[i] = 1'b0;
    end
    for (int c = 0; c < 500; c++) begin
      idle();
      for (int k = 0; k < NW; k++) begin
        if ($urandom_range(0, 2) != 0)
          set_wr(k, $urandom_range(0, 7), $urandom);
      end
      pset = ($urandom_range(0, 1) == 1);
      pset_addr = AW'($urandom_range(0, 7));
      for (int j = 0; j < NR; j++) set_rd(j, $urandom_range(0, 7));
      #1;
      for (int j = 0; j < NR; j++) begin
        a = int'(rd_addr[j*AW +: AW]);
        exp_d = model_mem[a];
        exp_p = model_pend[a];
        for (int k = NW - 1; k >= 0; k--) begin
          if (wr_en[k] && int'(wr_addr[k*AW +: AW]) == a) begin
            exp_d = wr_data[k*DW +: DW];
            exp_p = 1'b0;
            break;
          end
        end
        if (a == 0) begin
          exp_d = '0;
          exp_p = 1'b0;
        end
        vectors++;
        if (rd_data[j*DW +: DW] !== exp_d || rd_pend[j] !== exp_p) begin
          errors++;
          $display("FAIL rand c%0d p%0d r%0d data=%h pend=%b want %h/%b",
                   c, j, a, rd_data[j*DW +: DW], rd_pend[j], exp_d, exp_p);
        end
      end
      for (int k = 0; k < NW; k++) begin
        wa = int'(wr_addr[k*AW +: AW]);
        if (wr_en[k] && wa != 0) model_mem[wa] = wr_data[k*DW +: DW];
        if (wr_en[k]) model_pend[wa] = 1'b0;
      end
      if (pset && pset_addr != 0) model_pend[int'(pset_addr)] = 1'b1;
      tick();
    end
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    rd_addr = '0;
    tick();
    test_reset();
    test_init_write();
    test_bypass();
    test_priority();
    test_r0();
    test_scoreboard();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
